channel_tx: RTL and testbench

Router-side transmitter for the 8-bit YAPP output channel. Bytes of complete YAPP packets are written in, buffered store-and-forward, and replayed onto the channel as one contiguous `data_vld` burst per packet, honouring the receiver's `suspend` back-pressure. One instance sits behind each router output port and drives one channel interface.

---
 rtl/channel_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_channel_tx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_tx.sv
// channel_tx: store-and-forward YAPP packet transmitter for one 8-bit router output channel.
// Optional build macro CHANNEL_TX_PARITY_CHK_EN adds write-side parity checking (parity_err).
module channel_tx #(
  parameter int DEPTH = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_wr,
  output logic       in_full,
  output logic [7:0] data,
  output logic       data_vld,
  input  logic       suspend,
  output logic [6:0] pkt_pending,
  output logic       overflow,
  output logic       parity_err,
  output logic [1:0] dbg_wr_state,
  output logic [1:0] dbg_rd_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a byte is accepted at the edge where in_wr=1 and in_full=0; a channel
  // byte is consumed at the edge where data_vld=1 and suspend=0, otherwise it holds.

  typedef enum logic [1:0] {
    W_HDR = 2'd0,
    W_PAY = 2'd1,
    W_PAR = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SEND = 2'd1,
    R_GAP  = 2'd2
  } rd_state_e;

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [5:0]  pay_cnt_q, pay_cnt_d;
  logic [6:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        vld_q, vld_d;
  logic        full_q, full_d;
  logic [6:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  rd_byte;
  logic        push;
  logic        pop;
  logic        start;
  logic        pkt_done;
  logic        can_start;
  logic        last_byte;

  assign push      = in_wr & ~full_q;
  assign pkt_done  = push & (wr_state_q == W_PAR);
  assign rd_byte   = mem[rd_ptr_q[AW-1:0]];
  assign can_start = (pend_q != 7'd0) & ~suspend;
  assign last_byte = (byte_cnt_q == 7'd0);

  // ---------------- byte storage ----------------
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // ---------------- write-side parser ----------------
  always_comb begin
    wr_state_d = wr_state_q;
    pay_cnt_d  = pay_cnt_q;
    if (push) begin
      case (wr_state_q)
        W_HDR: begin
          pay_cnt_d  = in_data[7:2];
          wr_state_d = (in_data[7:2] == 6'd0) ? W_PAR : W_PAY;
        end
        W_PAY: begin
          pay_cnt_d = pay_cnt_q - 6'd1;
          if (pay_cnt_q == 6'd1) begin
            wr_state_d = W_PAR;
          end
        end
        W_PAR:   wr_state_d = W_HDR;
        default: wr_state_d = W_HDR;
      endcase
    end
  end

  // ---------------- read-side FSM: next state ----------------
  // GAP doubles as the launch point for a waiting packet, so consecutive
  // bursts are separated by exactly one idle cycle.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE: if (can_start) rd_state_d = R_SEND;
      R_SEND: if (!suspend && last_byte) rd_state_d = R_GAP;
      R_GAP:  rd_state_d = can_start ? R_SEND : R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // ---------------- read-side FSM: outputs ----------------
  always_comb begin
    pop        = 1'b0;
    start      = 1'b0;
    data_d     = data_q;
    vld_d      = vld_q;
    byte_cnt_d = byte_cnt_q;
    case (rd_state_q)
      R_IDLE, R_GAP: begin
        if (can_start) begin
          pop        = 1'b1;
          start      = 1'b1;
          data_d     = rd_byte;
          vld_d      = 1'b1;
          byte_cnt_d = {1'b0, rd_byte[7:2]} + 7'd1;
        end else begin
          vld_d = 1'b0;
        end
      end
      R_SEND: begin
        if (!suspend) begin
          if (last_byte) begin
            vld_d = 1'b0;
          end else begin
            pop        = 1'b1;
            data_d     = rd_byte;
            byte_cnt_d = byte_cnt_q - 7'd1;
          end
        end
      end
      default: vld_d = 1'b0;
    endcase
  end

  // ---------------- pointers, occupancy and status ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    ovf_d    = ovf_q | (in_wr & full_q);
    case ({pkt_done, start})
      2'b10:   pend_d = pend_q + 7'd1;
      2'b01:   pend_d = pend_q - 7'd1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_HDR;
      rd_state_q <= R_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pay_cnt_q  <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      full_q     <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pay_cnt_q  <= pay_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      full_q     <= full_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef CHANNEL_TX_PARITY_CHK_EN
  logic [7:0] acc_q, acc_d;
  logic       perr_q, perr_d;

  always_comb begin
    acc_d  = acc_q;
    perr_d = perr_q;
    if (push) begin
      case (wr_state_q)
        W_HDR:   acc_d = in_data;
        W_PAY:   acc_d = acc_q ^ in_data;
        W_PAR:   if (in_data != acc_q) perr_d = 1'b1;
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign in_full      = full_q;
  assign data         = data_q;
  assign data_vld     = vld_q;
  assign pkt_pending  = pend_q;
  assign overflow     = ovf_q;
  assign dbg_wr_state = wr_state_q;
  assign dbg_rd_state = rd_state_q;

  // A pop only ever targets stored bytes; a suspended byte stays on the channel.
  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
    pop |-> (rd_ptr_q != wr_ptr_q));
  a_suspend_hold: assert property (@(posedge clock) disable iff (reset)
    (rd_state_q == R_SEND && suspend) |=> (vld_q && $stable(data_q)));

endmodule

// File: tb/tb_channel_tx.sv
// tb_channel_tx: self-checking bench for channel_tx with a packet-level reference model.
// Define CHANNEL_TX_PARITY_CHK_EN for both files to exercise the parity checker.
module tb_channel_tx;

  localparam int DEPTH = 128;
`ifdef CHANNEL_TX_PARITY_CHK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_wr = 1'b0;
  logic       suspend = 1'b0;
  logic       in_full;
  logic [7:0] data;
  logic       data_vld;
  logic [6:0] pkt_pending;
  logic       overflow;
  logic       parity_err;
  logic [1:0] dbg_wr_state;
  logic [1:0] dbg_rd_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];

  channel_tx #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_wr       (in_wr),
    .in_full     (in_full),
    .data        (data),
    .data_vld    (data_vld),
    .suspend     (suspend),
    .pkt_pending (pkt_pending),
    .overflow    (overflow),
    .parity_err  (parity_err),
    .dbg_wr_state(dbg_wr_state),
    .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // Header {len, addr}, len random bytes, XOR parity over everything before it.
  task automatic build_pkt(input int len, input logic [1:0] addr);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] b;
    pkt_q.delete();
    hdr = {len[5:0], addr};
    par = hdr;
    pkt_q.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt_q.push_back(b);
      par = par ^ b;
    end
    pkt_q.push_back(par);
  endtask

  task automatic write_pkt(input int gap_max);
    int w;
    for (int i = 0; i < pkt_q.size(); i++) begin
      w = 0;
      while (in_full && w < 2000) begin
        step();
        w++;
      end
      total++;
      if (w >= 2000) begin
        bad++;
        $display("FAIL write_wait: in_full got=1 expected=0 within 2000 cycles");
      end
      exp_q.push_back(pkt_q[i]);
      in_data = pkt_q[i];
      in_wr   = 1'b1;
      step();
      in_wr   = 1'b0;
      repeat ($urandom_range(0, gap_max)) step();
    end
  endtask

  // Waits for a burst and scores it against exp_q; suspend must be low.
  task automatic expect_burst(input int max_wait, output int n);
    int w;
    logic [7:0] e;
    w = 0;
    n = 0;
    while (!data_vld && w < max_wait) begin
      step();
      w++;
    end
    total++;
    if (!data_vld) begin
      bad++;
      $display("FAIL burst_start: data_vld got=0 expected=1 after %0d cycles", w);
      return;
    end
    while (data_vld && n < 100) begin
      e = pop_exp();
      total++;
      if (data !== e) begin
        bad++;
        $display("FAIL burst_byte[%0d]: data got=%h expected=%h", n, data, e);
      end
      n++;
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    step();
    total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_data: got=%h expected=00", data); end
    total++; if (data_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got=%b expected=0", data_vld); end
    total++; if (in_full !== 1'b0) begin bad++; $display("FAIL rst_full: got=%b expected=0", in_full); end
    total++; if (pkt_pending !== 7'd0) begin bad++; $display("FAIL rst_pending: got=%0d expected=0", pkt_pending); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got=%b expected=0", overflow); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rst_parity_err: got=%b expected=0", parity_err); end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    pkt_q.delete();
    pkt_q.push_back(8'h09);
    pkt_q.push_back(8'hA1);
    pkt_q.push_back(8'hB2);
    pkt_q.push_back(8'h09 ^ 8'hA1 ^ 8'hB2);
    suspend = 1'b0;
    write_pkt(0);
    total++; if (pkt_pending !== 7'd1) begin bad++; $display("FAIL basic_pending: got=%0d expected=1", pkt_pending); end
    total++; if (data_vld !== 1'b0) begin bad++; $display("FAIL basic_latency: data_vld got=%b expected=0", data_vld); end
    step();
    total++; if (pkt_pending !== 7'd0) begin bad++; $display("FAIL basic_pending_dec: got=%0d expected=0", pkt_pending); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i < 4) begin
        e = pop_exp();
        if (data_vld !== 1'b1 || data !== e) begin
          bad++;
          $display("FAIL basic_byte[%0d]: vld=%b data=%h expected vld=1 data=%h", i, data_vld, data, e);
        end
      end else if (data_vld !== 1'b0) begin
        bad++;
        $display("FAIL basic_end: data_vld got=%b expected=0", data_vld);
      end
      step();
    end
  endtask

  task automatic test_suspend();
    int cyc;
    int idx;
    int w;
    bit did_susp;
    logic [7:0] e;
    build_pkt(5, 2'd2);
    suspend = 1'b1;
    write_pkt(0);
    suspend = 1'b0;
    w = 0;
    while (!data_vld && w < 20) begin step(); w++; end
    cyc = 0;
    idx = 0;
    did_susp = 1'b0;
    while (data_vld && cyc < 40) begin
      cyc++;
      e = pop_exp();
      total++;
      if (data !== e) begin bad++; $display("FAIL susp_byte[%0d]: got=%h expected=%h", idx, data, e); end
      if (idx == 1 && !did_susp) begin
        did_susp = 1'b1;
        suspend  = 1'b1;
        for (int k = 0; k < 3; k++) begin
          step();
          cyc++;
          total++;
          if (data_vld !== 1'b1 || data !== e) begin
            bad++;
            $display("FAIL susp_hold[%0d]: vld=%b data=%h expected vld=1 data=%h", k, data_vld, data, e);
          end
          if (k == 2) suspend = 1'b0;
        end
      end
      idx++;
      step();
    end
    total++; if (cyc != 10) begin bad++; $display("FAIL susp_burst_len: got=%0d expected=10", cyc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int lens[2];
    logic exp_vld[$];
    suspend = 1'b1;
    for (int p = 0; p < 2; p++) begin
      lens[p] = 0;
      build_pkt(lens[p], 2'($urandom));
      write_pkt(0);
    end
    total++; if (pkt_pending !== 7'd2) begin bad++; $display("FAIL b2b_pending2: got=%0d expected=2", pkt_pending); end
    for (int p = 0; p < 2; p++) begin
      repeat (lens[p] + 2) exp_vld.push_back(1'b1);
      exp_vld.push_back(1'b0);
    end
    suspend = 1'b0;
    step();
    for (int i = 0; i < exp_vld.size(); i++) begin
      total++;
      if (data_vld !== exp_vld[i]) begin
        bad++;
        $display("FAIL b2b_vld[%0d]: got=%b expected=%b", i, data_vld, exp_vld[i]);
      end else if (exp_vld[i]) begin
        e = pop_exp();
        total++;
        if (data !== e) begin bad++; $display("FAIL b2b_data[%0d]: got=%h expected=%h", i, data, e); end
      end
      if (i == 0) begin
        total++; if (pkt_pending !== 7'd1) begin bad++; $display("FAIL b2b_pending1: got=%0d expected=1", pkt_pending); end
      end
      if (i == 3) begin
        total++; if (pkt_pending !== 7'd0) begin bad++; $display("FAIL b2b_pending0: got=%0d expected=0", pkt_pending); end
      end
      step();
    end
  endtask

  task automatic test_fill_overflow();
    int n;
    bit seen;
    suspend = 1'b1;
    build_pkt(62, 2'd1);
    write_pkt(0);
    build_pkt(62, 2'd3);
    write_pkt(0);
    total++; if (in_full !== 1'b1) begin bad++; $display("FAIL fill_full: got=%b expected=1", in_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf: got=%b expected=0", overflow); end
    in_data = 8'hEE;
    in_wr   = 1'b1;
    step();
    in_wr   = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got=%b expected=1", overflow); end
    total++; if (in_full !== 1'b1) begin bad++; $display("FAIL ovf_full: got=%b expected=1", in_full); end
    total++; if (pkt_pending !== 7'd2) begin bad++; $display("FAIL ovf_pending: got=%0d expected=2", pkt_pending); end
    suspend = 1'b0;
    for (int p = 0; p < 2; p++) begin
      expect_burst(5, n);
      total++; if (n != 64) begin bad++; $display("FAIL fill_burst_len[%0d]: got=%0d expected=64", p, n); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fill_leftover: got=%0d expected=0 bytes", exp_q.size()); end
    seen = 1'b0;
    repeat (8) begin
      if (data_vld) seen = 1'b1;
      step();
    end
    total++; if (seen) begin bad++; $display("FAIL fill_extra: data_vld got=1 expected=0 after drain"); end
    total++; if (in_full !== 1'b0) begin bad++; $display("FAIL fill_drained: in_full got=%b expected=0", in_full); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    int w;
    int n;
    bit seen;
    build_pkt(8, 2'd0);
    suspend = 1'b1;
    write_pkt(0);
    suspend = 1'b0;
    w = 0;
    while (!data_vld && w < 20) begin step(); w++; end
    step();
    step();
    total++; if (data_vld !== 1'b1 || data !== pkt_q[2]) begin
      bad++; $display("FAIL rmb_byte3: vld=%b data=%h expected vld=1 data=%h", data_vld, data, pkt_q[2]);
    end
    #2 reset = 1'b1;
    #1;
    total++; if (data_vld !== 1'b0) begin bad++; $display("FAIL rmb_async_vld: got=%b expected=0", data_vld); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmb_overflow: got=%b expected=0", overflow); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL rmb_data: got=%h expected=00", data); end
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    total++; if (pkt_pending !== 7'd0) begin bad++; $display("FAIL rmb_pending: got=%0d expected=0", pkt_pending); end
    seen = 1'b0;
    repeat (20) begin
      step();
      if (data_vld) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rmb_empty: data_vld got=1 expected=0 with empty FIFO"); end
    build_pkt(3, 2'd1);
    write_pkt(0);
    expect_burst(5, n);
    total++; if (n != 5) begin bad++; $display("FAIL rmb_after_len: got=%0d expected=5", n); end
  endtask

  task automatic test_parity();
    int n;
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clean: got=%b expected=0", parity_err); end
    pkt_q.delete();
    pkt_q.push_back(8'h04);
    pkt_q.push_back(8'h55);
    pkt_q.push_back(8'h00);
    suspend = 1'b1;
    write_pkt(0);
    total++; if (parity_err !== PAR_EN) begin bad++; $display("FAIL par_err: got=%b expected=%b", parity_err, PAR_EN); end
    suspend = 1'b0;
    expect_burst(5, n);
    total++; if (n != 3) begin bad++; $display("FAIL par_sent_len: got=%0d expected=3", n); end
  endtask

  task automatic test_random();
    bit wr_done;
    wr_done = 1'b0;
    suspend = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int p = 0; p < 16; p++) begin
          build_pkt($urandom_range(0, 63), 2'($urandom));
          write_pkt(2);
        end
        wr_done = 1'b1;
      end
      begin
        logic prev_vld;
        logic prev_susp;
        logic [7:0] held;
        logic [7:0] e;
        int remaining;
        int cyc;
        bit done;
        prev_vld  = 1'b0;
        prev_susp = 1'b0;
        held      = 8'h00;
        remaining = 0;
        cyc       = 0;
        done      = 1'b0;
        while (!done && cyc < 20000) begin
          step();
          cyc++;
          if (data_vld) begin
            if (prev_vld && prev_susp) begin
              total++;
              if (data !== held) begin bad++; $display("FAIL rnd_hold: got=%h expected=%h", data, held); end
            end else begin
              if (remaining == 0) begin
                total++;
                if (prev_vld) begin bad++; $display("FAIL rnd_gap: data_vld got=1 expected=0 between packets"); end
              end
              e = pop_exp();
              total++;
              if (data !== e) begin bad++; $display("FAIL rnd_byte: got=%h expected=%h", data, e); end
              if (remaining == 0) remaining = int'(e[7:2]) + 2;
              remaining--;
              held = e;
            end
          end else if (prev_vld) begin
            total++;
            if (prev_susp || remaining != 0) begin
              bad++;
              $display("FAIL rnd_burst_break: data_vld got=0 expected=1 (remaining=%0d)", remaining);
            end
          end
          prev_vld  = data_vld;
          suspend   = ($urandom_range(0, 3) == 0);
          prev_susp = suspend;
          if (wr_done && exp_q.size() == 0 && remaining == 0 && !data_vld) done = 1'b1;
        end
        suspend = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL rnd_timeout: %0d bytes still expected", exp_q.size()); end
      end
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_suspend();
    test_back_to_back();
    test_fill_overflow();
    test_reset_mid_burst();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
